// File: rtl/intr_ctrl.sv
// Priority interrupt controller: edge-latched sources, mask, req/ack/EOI handshake.
// Define INTR_CTRL_RR_EN for round-robin selection instead of fixed priority.
module intr_ctrl #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq,
   input  logic             int_ack,
   input  logic             cs,
   input  logic             wr,
   input  logic             rd,
   input  logic [1:0]       addr,
   input  logic [31:0]      din,
   output logic             intr,
   output logic             busy,
   output logic [31:0]      dout
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t           state, state_nxt;
   logic [N_SRC-1:0] pending, pending_nxt;
   logic [N_SRC-1:0] irq_prev;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] eligible;
   logic [N_SRC-1:0] edges;
   logic [N_SRC-1:0] one_hot;
   logic [4:0]       active_id;
   logic             spurious;
   logic [4:0]       sel;
   logic             any_elig;
   logic             ack_take;
   logic             intr_nxt;
   logic             w_pend, w_mask, w_eoi;
   logic             unused_din;

   assign unused_din = ^din;

   assign edges    = irq & ~irq_prev;
   assign eligible = pending & mask;
   assign any_elig = |eligible;

   assign w_pend = cs && wr && (addr == 2'd0);
   assign w_mask = cs && wr && (addr == 2'd1);
   assign w_eoi  = cs && wr && (addr == 2'd3);

   assign busy = (state == SERVICE);

`ifdef INTR_CTRL_RR_EN
   logic [4:0] last_id;

   // Scan upward starting just past the last serviced id, wrapping.
   always_comb begin
      logic             found;
      int               idx;
      logic [N_SRC-1:0] rot;
      found = 1'b0;
      sel   = '0;
      idx   = 0;
      rot   = '0;
      for (int k = 0; k < N_SRC; k++) begin
         idx = (int'(last_id) + 1 + k) % N_SRC;
         rot = eligible >> idx;
         if (!found && rot[0]) begin
            found = 1'b1;
            sel   = 5'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_id <= '0;
      end else if (ack_take && any_elig) begin
         last_id <= sel;
      end
   end
`else
   always_comb begin
      sel = '0;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         if (eligible[k]) sel = 5'(k);
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      ack_take  = 1'b0;
      unique case (state)
         IDLE:    if (any_elig) state_nxt = REQ;
         REQ: begin
            if (int_ack) begin
               state_nxt = SERVICE;
               ack_take  = 1'b1;
            end
         end
         SERVICE: if (w_eoi) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      intr_nxt = (state_nxt == REQ);
   end

   // Clears first, then new edges so a simultaneous set wins.
   always_comb begin
      one_hot     = '0;
      one_hot[0]  = 1'b1;
      pending_nxt = pending;
      if (w_pend) pending_nxt = pending_nxt & ~din[N_SRC-1:0];
      if (ack_take && any_elig) pending_nxt = pending_nxt & ~(one_hot << sel);
      pending_nxt = pending_nxt | edges;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         intr      <= 1'b0;
         pending   <= '0;
         irq_prev  <= '0;
         mask      <= '1;
         active_id <= '0;
         spurious  <= 1'b0;
      end else begin
         state    <= state_nxt;
         intr     <= intr_nxt;
         pending  <= pending_nxt;
         irq_prev <= irq;
         if (w_mask) mask <= din[N_SRC-1:0];
         if (ack_take) begin
            active_id <= any_elig ? sel : 5'h1F;
            spurious  <= !any_elig;
         end
      end
   end

   always_comb begin
      dout = '0;
      if (reset && cs && rd) begin
         case (addr)
            2'd0:    dout = 32'(pending);
            2'd1:    dout = 32'(mask);
            2'd2:    dout = spurious ? 32'hFFFF_FFFF : 32'(active_id);
            default: dout = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl.
// Covers single/priority/mask/spurious/collision/reset and optional round-robin.
module tb_intr_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  irq;
   logic        int_ack;
   logic        cs, wr, rd;
   logic [1:0]  addr;
   logic [31:0] din;
   logic        intr, busy;
   logic [31:0] dout;
   logic [31:0] v;
   int          checks = 0;
   int          errors = 0;

   intr_ctrl #(.N_SRC(8)) dut (
      .clk(clk), .reset(reset), .irq(irq), .int_ack(int_ack),
      .cs(cs), .wr(wr), .rd(rd), .addr(addr), .din(din),
      .intr(intr), .busy(busy), .dout(dout)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
      cs = 1'b1; rd = 1'b1; addr = a;
      #1;
      d = dout;
      cs = 1'b0; rd = 1'b0;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; din = d;
      tick();
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic ack();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b0; irq = '0; int_ack = 1'b0;
      cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; din = '0;
      repeat (2) @(posedge clk);
      #5 reset = 1'b1;
      tick();

      chk("rst_intr", 32'(intr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rd_reg(2'd0, v); chk("rst_pend", v, 32'h0);
      rd_reg(2'd1, v); chk("rst_mask", v, 32'hFF);
      rd_reg(2'd2, v); chk("rst_vec", v, 32'h0);
      rd_reg(2'd3, v); chk("eoi_rd", v, 32'h0);

      // single source
      wr_reg(2'd1, 32'hFF);
      irq = 8'h08; tick(); irq = '0;
      rd_reg(2'd0, v); chk("s_pend", v, 32'h08);
      chk("s_intr_t1", 32'(intr), 32'd0);
      tick();
      chk("s_intr_t2", 32'(intr), 32'd1);
      ack();
      chk("s_intr_ack", 32'(intr), 32'd0);
      chk("s_busy", 32'(busy), 32'd1);
      rd_reg(2'd2, v); chk("s_vec", v, 32'd3);
      rd_reg(2'd0, v); chk("s_pend_clr", v, 32'h0);
      wr_reg(2'd3, 32'h0);
      chk("s_eoi_busy", 32'(busy), 32'd0);
      ack();
      chk("idle_ack", 32'(busy), 32'd0);

      // priority, EOI ignored in REQ, back-to-back
      irq = 8'h24; tick(); irq = '0; tick();
      chk("p_intr", 32'(intr), 32'd1);
      wr_reg(2'd3, 32'h0);
      chk("p_eoi_req", 32'(intr), 32'd1);
      ack();
      rd_reg(2'd2, v); chk("p_vec2", v, 32'd2);
      rd_reg(2'd0, v); chk("p_pend", v, 32'h20);
      wr_reg(2'd3, 32'h0);
      chk("p_after_eoi", 32'(intr), 32'd0);
      tick();
      chk("p_reassert", 32'(intr), 32'd1);
      ack();
      rd_reg(2'd2, v); chk("p_vec5", v, 32'd5);
      wr_reg(2'd3, 32'h0);

      // masking
      wr_reg(2'd1, 32'hF7);
      irq = 8'h08; tick(); irq = '0; tick(); tick();
      rd_reg(2'd0, v); chk("m_pend", v, 32'h08);
      chk("m_intr", 32'(intr), 32'd0);
      wr_reg(2'd1, 32'hFF);
      tick();
      chk("m_intr_en", 32'(intr), 32'd1);
      ack();
      rd_reg(2'd2, v); chk("m_vec", v, 32'd3);
      wr_reg(2'd3, 32'h0);

      // spurious
      irq = 8'h02; tick(); irq = '0; tick();
      chk("sp_intr", 32'(intr), 32'd1);
      wr_reg(2'd0, 32'h02);
      chk("sp_hold", 32'(intr), 32'd1);
      ack();
      rd_reg(2'd2, v); chk("sp_vec", v, 32'hFFFF_FFFF);
      chk("sp_busy", 32'(busy), 32'd1);

      // set/clear collision and held-high line
      irq = 8'h40; tick(); irq = '0; tick();
      rd_reg(2'd0, v); chk("c_pend", v, 32'h40);
      irq = 8'h40;
      wr_reg(2'd0, 32'h40);
      rd_reg(2'd0, v); chk("c_setwins", v, 32'h40);
      wr_reg(2'd0, 32'h40);
      tick();
      rd_reg(2'd0, v); chk("c_held", v, 32'h0);
      irq = '0;
      wr_reg(2'd3, 32'h0);
      tick();
      chk("c_idle", 32'(intr), 32'd0);

      // reset mid-service
      wr_reg(2'd1, 32'h1F);
      irq = 8'h01; tick(); irq = '0; tick();
      ack();
      irq = 8'h10; tick(); irq = '0;
      rd_reg(2'd0, v); chk("r_pend", v, 32'h10);
      chk("r_busy", 32'(busy), 32'd1);
      #1 reset = 1'b0;
      #1;
      chk("r_intr", 32'(intr), 32'd0);
      chk("r_busy0", 32'(busy), 32'd0);
      rd_reg(2'd1, v); chk("r_dout0", v, 32'h0);
      #1 reset = 1'b1;
      rd_reg(2'd0, v); chk("r_pend0", v, 32'h0);
      rd_reg(2'd1, v); chk("r_mask", v, 32'hFF);
      tick(); tick();
      chk("r_quiet", 32'(intr), 32'd0);

`ifdef INTR_CTRL_RR_EN
      irq = 8'h12; tick(); irq = '0; tick();
      chk("rr_intr", 32'(intr), 32'd1);
      ack();
      rd_reg(2'd2, v); chk("rr_vec1", v, 32'd1);
      wr_reg(2'd3, 32'h0);
      irq = 8'h02; tick(); irq = '0;
      ack();
      rd_reg(2'd2, v); chk("rr_vec4", v, 32'd4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
